// File: rtl/sbm_pkg.sv
// Shared definitions for the digit-serial schoolbook multiplier.
//   state_t  : controller states
//   ceil_div : rounded-up division, used to derive the digit count of b
//   cnt_w    : counter width able to index n positions (at least 1 bit)
package sbm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int ceil_div(input int n, input int d);
    return (n + d - 1) / d;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sbm_digit_unit.sv
// Shift-add digit unit: multiplies operand a by one DIGIT_W-bit digit of b,
// consuming STEP digit bits per enabled cycle (STEPS = DIGIT_W/STEP cycles).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clr      : clears partial and step counter
//   en       : perform one step
//   a        : multiplicand (held stable by the caller during a digit)
//   digit    : current digit of b
//   partial  : running a * digit, SIZEA+DIGIT_W bits (cannot overflow)
//   last     : the step being performed is the final one of the digit
module sbm_digit_unit
  import sbm_pkg::*;
#(
  parameter int SIZEA   = 521,
  parameter int DIGIT_W = 32,
  parameter int STEP    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic [SIZEA-1:0]         a,
  input  logic [DIGIT_W-1:0]       digit,
  output logic [SIZEA+DIGIT_W-1:0] partial,
  output logic                     last
);

  localparam int STEPS = DIGIT_W / STEP;
  localparam int KW    = cnt_w(STEPS);
  localparam int PW    = SIZEA + DIGIT_W;

  logic [KW-1:0]   k;
  int              koff;
  logic [STEP-1:0] chunk;
  logic [PW-1:0]   term;

  assign koff  = int'(k) * STEP;
  assign chunk = digit[koff +: STEP];
  assign last  = (k == KW'(STEPS - 1));

  // a * chunk built from shifted copies of a, so no hardware multiplier
  // is needed whatever STEP is.
  always_comb begin
    term = '0;
    for (int unsigned j = 0; j < STEP; j++) begin
      if (chunk[j]) term = term + (PW'(a) << j);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      partial <= '0;
      k       <= '0;
    end else if (en) begin
      partial <= partial + (term << koff);
      k       <= last ? '0 : k + 1'b1;
    end
  end

endmodule

// File: rtl/sbm_digit_serial.sv
// Digit-serial schoolbook multiplier, c = a * b (unsigned).
// b is split into DIGITS digits of DIGIT_W bits; each digit is multiplied by
// a in sbm_digit_unit and the partial product is added into the accumulator
// at offset DIGIT_W*d.
// Ports:
//   clk, rst : clock, synchronous active-high reset (priority in all states)
//   start    : request, sampled only in IDLE; a/b captured when accepted
//   a, b     : operands
//   busy     : high from the cycle after accept through the done cycle
//   done     : one-cycle pulse, c valid in the same cycle
//   c        : product, held until the next accepted operation completes
module sbm_digit_serial
  import sbm_pkg::*;
#(
  parameter int SIZEA   = 521,
  parameter int SIZEB   = 521,
  parameter int DIGIT_W = 32,
  parameter int STEP    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [SIZEA-1:0]       a,
  input  logic [SIZEB-1:0]       b,
  output logic                   busy,
  output logic                   done,
  output logic [SIZEA+SIZEB-1:0] c
);

  localparam int DIGITS = ceil_div(SIZEB, DIGIT_W);
  localparam int BW     = DIGITS * DIGIT_W;
  localparam int CW     = SIZEA + SIZEB;
  localparam int EW     = SIZEA + BW;
  localparam int PW     = SIZEA + DIGIT_W;
  localparam int DW     = cnt_w(DIGITS);

  state_t             state, state_nxt;
  logic [DW-1:0]      d;
  int                 d_int;
  logic [SIZEA-1:0]   a_reg;
  logic [BW-1:0]      b_reg;
  logic [CW-1:0]      acc;
  logic [CW-1:0]      acc_sum;
  logic [DIGIT_W-1:0] digit;
  logic [PW-1:0]      partial;
  logic               last_step;
  logic               last_digit;
  logic               load;
  logic               dig_en;
  logic               dig_clr;

  assign d_int      = int'(d);
  assign digit      = b_reg[d_int*DIGIT_W +: DIGIT_W];
  assign last_digit = (d == DW'(DIGITS - 1));

  // Shifted partial is widened first so no bits are lost in the shift; the
  // running sum never exceeds the final product, so truncating to CW is exact.
  assign acc_sum = acc + CW'(EW'(partial) << (DIGIT_W * d_int));

  sbm_digit_unit #(
    .SIZEA   (SIZEA),
    .DIGIT_W (DIGIT_W),
    .STEP    (STEP)
  ) u_digit (
    .clk     (clk),
    .rst     (rst),
    .clr     (dig_clr),
    .en      (dig_en),
    .a       (a_reg),
    .digit   (digit),
    .partial (partial),
    .last    (last_step)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    dig_en    = 1'b0;
    dig_clr   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          load      = 1'b1;
          dig_clr   = 1'b1;
          state_nxt = ST_MUL;
        end
      end
      ST_MUL: begin
        dig_en = 1'b1;
        if (last_step) state_nxt = ST_ACC;
      end
      ST_ACC: begin
        dig_clr   = 1'b1;
        state_nxt = last_digit ? ST_DONE : ST_MUL;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // c is loaded on the final ACC edge so it is already valid in the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      d     <= '0;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      c     <= '0;
    end else begin
      if (load) begin
        a_reg <= a;
        b_reg <= BW'(b);
        acc   <= '0;
        d     <= '0;
      end
      if (state == ST_ACC) begin
        acc <= acc_sum;
        if (last_digit) c <= acc_sum;
        else            d <= d + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sbm_digit_serial.sv
// Self-checking bench for sbm_digit_serial: several parameterisations run in
// parallel, table vectors, directed corner sequences and random operands
// compared against a plain-multiplication reference.
module tb_sbm_digit_serial;

  typedef logic [1041:0] wide_t;

  localparam int N = 6;
  localparam int PSA [N] = '{8, 521, 37, 23, 37, 37};
  localparam int PSB [N] = '{8, 521, 37, 37, 37, 37};
  localparam int PDW [N] = '{4, 32, 8, 8, 8, 8};
  localparam int PST [N] = '{2, 1, 1, 2, 4, 8};

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] start_v;
  logic [N-1:0] busy_v;
  logic [N-1:0] done_v;
  logic [520:0] a_v [N];
  logic [520:0] b_v [N];
  wide_t        c_v [N];

  int tests = 0;
  int fails = 0;
  bit hold  = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [PSA[g]+PSB[g]-1:0] c_w;
    sbm_digit_serial #(
      .SIZEA   (PSA[g]),
      .SIZEB   (PSB[g]),
      .DIGIT_W (PDW[g]),
      .STEP    (PST[g])
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start_v[g]),
      .a     (a_v[g][PSA[g]-1:0]),
      .b     (b_v[g][PSB[g]-1:0]),
      .busy  (busy_v[g]),
      .done  (done_v[g]),
      .c     (c_w)
    );
    assign c_v[g] = wide_t'(c_w);
  end

  typedef struct {
    wide_t a;
    wide_t b;
    wide_t exp;
  } vec_t;

  function automatic int first_diff(input wide_t x, input wide_t y);
    for (int i = 0; i < 1042; i++) if (x[i] !== y[i]) return i;
    return -1;
  endfunction

  task automatic check(input string name, input wide_t act, input wide_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (low 400 bits shown, first differing bit %0d)",
               name, act[399:0], exp[399:0], first_diff(act, exp));
    end
  endtask

  function automatic int lat_of(input int idx);
    int digits = (PSB[idx] + PDW[idx] - 1) / PDW[idx];
    return digits * (PDW[idx] / PST[idx] + 1) + 1;
  endfunction

  function automatic wide_t mask(input wide_t v, input int w);
    wide_t m;
    m = '1;
    m = m << w;
    return v & ~m;
  endfunction

  function automatic wide_t rand_wide();
    wide_t r = '0;
    for (int i = 0; i < 33; i++) r = (r << 32) | wide_t'($urandom);
    return r;
  endfunction

  function automatic wide_t ref_mul(input int idx, input wide_t a, input wide_t b);
    return mask(a, PSA[idx]) * mask(b, PSB[idx]);
  endfunction

  task automatic launch(input int idx, input wide_t a, input wide_t b);
    @(negedge clk);
    check($sformatf("idle_before_start[%0d]", idx), wide_t'(busy_v[idx]), '0);
    a_v[idx]     = a[520:0];
    b_v[idx]     = b[520:0];
    start_v[idx] = 1'b1;
    @(posedge clk);
  endtask

  // Counts cycles after the accept edge until done; lat=-1 on timeout.
  task automatic wait_done(input int idx, output int lat, output int nbusy);
    int lim = lat_of(idx) + 20;
    lat   = -1;
    nbusy = 0;
    for (int n = 1; n <= lim; n++) begin
      @(negedge clk);
      if (!hold) start_v[idx] = 1'b0;
      if (busy_v[idx]) nbusy++;
      if (done_v[idx]) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic run_check(input int idx, input wide_t a, input wide_t b,
                           input wide_t exp, input string name);
    int lat, nb;
    launch(idx, a, b);
    wait_done(idx, lat, nb);
    check({name, ".latency"}, wide_t'(lat), wide_t'(lat_of(idx)));
    check({name, ".c"}, c_v[idx], exp);
    check({name, ".busy_cycles"}, wide_t'(nb), wide_t'(lat_of(idx)));
    @(negedge clk);
    check({name, ".idle_after"}, wide_t'({busy_v[idx], done_v[idx]}), '0);
    check({name, ".c_held"}, c_v[idx], exp);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl [8];
    wide_t ra, rb, e;
    int    lat, nb;

    rst     = 1'b1;
    start_v = '0;
    for (int i = 0; i < N; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("reset_busy_done[%0d]", i), wide_t'({busy_v[i], done_v[i]}), '0);
      check($sformatf("reset_c[%0d]", i), c_v[i], '0);
    end
    rst = 1'b0;

    // 8x8, DIGIT_W=4, STEP=2 table
    tbl[0] = '{a: 255, b: 255, exp: 65025};
    tbl[1] = '{a: 0,   b: 77,  exp: 0};
    tbl[2] = '{a: 1,   b: 200, exp: 200};
    tbl[3] = '{a: 16,  b: 16,  exp: 256};
    tbl[4] = '{a: 13,  b: 11,  exp: 143};
    tbl[5] = '{a: 128, b: 2,   exp: 256};
    tbl[6] = '{a: 255, b: 1,   exp: 255};
    tbl[7] = '{a: 170, b: 85,  exp: 14450};
    for (int i = 0; i < 8; i++)
      run_check(0, tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("tbl%0d", i));

    // all-ones operands at default sizes
    ra = mask('1, 521);
    e  = '0;
    e  = e - (wide_t'(1) << 522) + wide_t'(1);
    run_check(1, ra, ra, e, "max521");

    // zero and identity operands at default sizes
    rb = rand_wide();
    run_check(1, '0, rb, '0, "a_zero");
    ra = rand_wide();
    run_check(1, ra, '0, '0, "b_zero");
    rb = rand_wide();
    run_check(1, wide_t'(1), rb, mask(rb, 521), "a_one");

    // start held high, operands changed mid-run, no queued accept in DONE
    hold = 1'b1;
    launch(0, 200, 100);
    #2;
    a_v[0] = 3;
    b_v[0] = 5;
    wait_done(0, lat, nb);
    check("hold.latency1", wide_t'(lat), wide_t'(lat_of(0)));
    check("hold.c1", c_v[0], 20000);
    @(negedge clk);
    check("hold.idle_gap", wide_t'(busy_v[0]), '0);
    check("hold.c1_held", c_v[0], 20000);
    wait_done(0, lat, nb);
    check("hold.latency2", wide_t'(lat), wide_t'(lat_of(0)));
    check("hold.c2", c_v[0], 15);
    hold       = 1'b0;
    start_v[0] = 1'b0;
    @(negedge clk);
    check("hold.released", wide_t'(busy_v[0]), '0);

    // reset in the middle of a multiply
    ra = rand_wide();
    rb = rand_wide();
    launch(1, ra, rb);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      start_v[1] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort.busy_done", wide_t'({busy_v[1], done_v[1]}), '0);
    check("abort.c", c_v[1], '0);
    ra = rand_wide();
    rb = rand_wide();
    run_check(1, ra, rb, ref_mul(1, ra, rb), "after_abort");

    // random regression across STEP values and ragged SIZEB
    for (int idx = 2; idx < N; idx++) begin
      run_check(idx, '1, '1, ref_mul(idx, '1, '1), $sformatf("ones[%0d]", idx));
      for (int r = 0; r < 6; r++) begin
        ra = rand_wide();
        rb = rand_wide();
        run_check(idx, ra, rb, ref_mul(idx, ra, rb), $sformatf("rnd[%0d].%0d", idx, r));
      end
    end
    for (int r = 0; r < 2; r++) begin
      ra = rand_wide();
      rb = rand_wide();
      run_check(0, ra, rb, ref_mul(0, ra, rb), $sformatf("rnd8.%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
